bit_crusher_sr: RTL and testbench

Parametrised stereo lo-fi effect stage. It combines bit-depth reduction (variable LSB truncation or rounding) with sample-rate reduction (sample-and-hold decimation).
- Sits in the pedalboard audio chain between codec input and the next effect.
- Operates on a per-sample valid strobe.
- Outputs are registered.
- Bypass is selected by switch.

---
 rtl/bit_crusher_sr_if.sv | 22 ++
 rtl/bit_crusher_sr.sv | 105 ++++++++++
 tb/tb_bit_crusher_sr.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bit_crusher_sr_if.sv
// Sample stream bundle for the bit crusher: stereo input strobe/data and
// registered stereo output strobe/data.
interface bit_crusher_sr_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] l_audio_in;
    logic [DATA_W-1:0] r_audio_in;
    logic              out_valid;
    logic [DATA_W-1:0] l_audio_out;
    logic [DATA_W-1:0] r_audio_out;

    modport master (
        output in_valid, l_audio_in, r_audio_in,
        input  out_valid, l_audio_out, r_audio_out
    );

    modport slave (
        input  in_valid, l_audio_in, r_audio_in,
        output out_valid, l_audio_out, r_audio_out
    );
endinterface

// File: rtl/bit_crusher_sr.sv
// Stereo lo-fi stage: per-lane bit-depth reduction (truncate or saturating
// round) followed by a shared sample-and-hold decimator, 1-cycle latency.
module bit_crusher_lane #(
    parameter int DATA_W  = 32,
    parameter int CRUSH_W = 5
) (
    input  logic               round_en,
    input  logic [CRUSH_W-1:0] crush_bits,
    input  logic [DATA_W-1:0]  x,
    output logic [DATA_W-1:0]  y
);
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    int unsigned       k;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] half;
    logic [DATA_W:0]   s;

    always_comb begin
        k    = (32'(crush_bits) > 32'(DATA_W-1)) ? 32'(DATA_W-1) : 32'(crush_bits);
        mask = {DATA_W{1'b1}} << k;
        half = (k == 0) ? '0 : (DATA_W'(1) << (k - 1));
        // One extra bit so a positive overflow is visible instead of wrapping
        s    = {x[DATA_W-1], x} + {1'b0, half};
        y    = x & mask;
        if (round_en && k != 0) begin
            y = (!s[DATA_W] && s[DATA_W-1]) ? (MAX_POS & mask) : (s[DATA_W-1:0] & mask);
        end
    end
endmodule

module bit_crusher_sr #(
    parameter int DATA_W  = 32,
    parameter int CRUSH_W = 5,
    parameter int HOLD_W  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               round_en,
    input  logic [CRUSH_W-1:0] crush_bits,
    input  logic [HOLD_W-1:0]  hold_factor,
    bit_crusher_sr_if.slave    bus
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][DATA_W-1:0] raw;
    logic [NUM_LANES-1:0][DATA_W-1:0] crushed;
    logic [NUM_LANES-1:0][DATA_W-1:0] held;
    logic [NUM_LANES-1:0][DATA_W-1:0] out;
    logic [HOLD_W-1:0]                hold_cnt;
    logic [HOLD_W:0]                  cnt_inc;
    logic [HOLD_W:0]                  hold_len;
    logic                             out_valid;

    // Lane 0 is left, lane 1 is right
    assign raw = {bus.r_audio_in, bus.l_audio_in};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            bit_crusher_lane #(
                .DATA_W  (DATA_W),
                .CRUSH_W (CRUSH_W)
            ) u_lane (
                .round_en   (round_en),
                .crush_bits (crush_bits),
                .x          (raw[g]),
                .y          (crushed[g])
            );
        end
    endgenerate

    // Compared one bit wider so the counter never wraps at its maximum
    assign hold_len = (hold_factor == '0) ? (HOLD_W+1)'(1) : {1'b0, hold_factor};
    assign cnt_inc  = {1'b0, hold_cnt} + (HOLD_W+1)'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            held      <= '0;
            hold_cnt  <= '0;
        end else begin
            out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                if (!enable) begin
                    out      <= raw;
                    hold_cnt <= '0;
                end else begin
                    if (hold_cnt == '0) begin
                        held <= crushed;
                        out  <= crushed;
                    end else begin
                        out  <= held;
                    end
                    hold_cnt <= (cnt_inc >= hold_len) ? '0 : cnt_inc[HOLD_W-1:0];
                end
            end
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.l_audio_out = out[0];
    assign bus.r_audio_out = out[1];
endmodule

// File: tb/tb_bit_crusher_sr.sv
// Bench for bit_crusher_sr: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference of the effect.
module tb_bit_crusher_sr;
    localparam int     DATA_W  = 32;
    localparam int     CRUSH_W = 5;
    localparam int     HOLD_W  = 4;
    localparam longint MAX_POS = 64'sd2147483647;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b0;
    logic               round_en = 1'b0;
    logic [CRUSH_W-1:0] crush_bits = '0;
    logic [HOLD_W-1:0]  hold_factor = '0;

    int n_tests = 0;
    int n_fail  = 0;

    bit_crusher_sr_if #(.DATA_W(DATA_W)) bus();

    bit_crusher_sr #(
        .DATA_W  (DATA_W),
        .CRUSH_W (CRUSH_W),
        .HOLD_W  (HOLD_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .round_en    (round_en),
        .crush_bits  (crush_bits),
        .hold_factor (hold_factor),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reduce to a multiple of 2^k by floor, optionally after adding half a step,
    // clipping at the largest positive sample first.
    function automatic logic [31:0] crush_m(input logic [31:0] x, input int cb, input bit rnd);
        longint v;
        longint p;
        int     k;
        k = (cb > DATA_W-1) ? DATA_W-1 : cb;
        p = longint'(1) << k;
        v = longint'($signed(x));
        if (rnd && k > 0) v = v + p / 2;
        if (v > MAX_POS) v = MAX_POS;
        v = v - (((v % p) + p) % p);
        return v[31:0];
    endfunction

    logic [31:0] m_l, m_r, m_hl, m_hr;
    int          m_since;
    bit          exp_v;

    always @(posedge clk) begin
        int h;
        if (!reset_n) begin
            m_l = '0; m_r = '0; m_hl = '0; m_hr = '0;
            m_since = 0;
            exp_v = 1'b0;
        end else begin
            exp_v = bus.in_valid;
            if (bus.in_valid) begin
                if (!enable) begin
                    m_l = bus.l_audio_in;
                    m_r = bus.r_audio_in;
                    m_since = 0;
                end else begin
                    h = (hold_factor == 0) ? 1 : int'(hold_factor);
                    if (m_since == 0) begin
                        m_hl = crush_m(bus.l_audio_in, int'(crush_bits), round_en);
                        m_hr = crush_m(bus.r_audio_in, int'(crush_bits), round_en);
                    end
                    m_l = m_hl;
                    m_r = m_hr;
                    m_since = m_since + 1;
                    if (m_since >= h) m_since = 0;
                end
            end
        end
        #1;
        chk("mon_valid", 32'(bus.out_valid), 32'(exp_v));
        chk("mon_l", bus.l_audio_out, m_l);
        chk("mon_r", bus.r_audio_out, m_r);
    end

    task automatic send(input bit en, input bit rnd, input int cb, input int hf,
                        input logic [31:0] l, input logic [31:0] r,
                        input logic [31:0] el, input logic [31:0] er, input string name);
        @(negedge clk);
        enable         = en;
        round_en       = rnd;
        crush_bits     = CRUSH_W'(cb);
        hold_factor    = HOLD_W'(hf);
        bus.in_valid   = 1'b1;
        bus.l_audio_in = l;
        bus.r_audio_in = r;
        @(posedge clk);
        #2;
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_l"}, bus.l_audio_out, el);
        chk({name, "_r"}, bus.r_audio_out, er);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    int dec_exp [7] = '{1, 1, 1, 4, 4, 4, 7};

    initial begin
        bus.in_valid   = 1'b0;
        bus.l_audio_in = '0;
        bus.r_audio_in = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_l", bus.l_audio_out, 32'd0);
        chk("rst_r", bus.r_audio_out, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        send(0, 0, 0, 1, 32'h1234_5678, 32'hFFFF_FF01, 32'h1234_5678, 32'hFFFF_FF01, "bypass");
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_l", bus.l_audio_out, 32'd0);
        chk("async_rst_r", bus.r_audio_out, 32'd0);
        idle(1);
        @(negedge clk) reset_n = 1'b1;

        send(1, 0, 8, 1, 32'h0000_12FF, 32'hFFFF_FF7F, 32'h0000_1200, 32'hFFFF_FF00, "trunc");
        send(1, 0, 0, 1, 32'h0000_12FF, 32'hFFFF_FF7F, 32'h0000_12FF, 32'hFFFF_FF7F, "k0");
        send(1, 1, 8, 1, 32'h0000_1280, 32'h0000_127F, 32'h0000_1300, 32'h0000_1200, "round");
        send(1, 1, 8, 1, 32'h7FFF_FFF0, 32'hFFFF_FF80, 32'h7FFF_FF00, 32'h0000_0000, "round_sat");
        send(1, 1, 4, 0, 32'h0000_0017, 32'hFFFF_FFF8, 32'h0000_0010, 32'h0000_0000, "hf0");
        idle(1);

        for (int i = 1; i <= 7; i++)
            send(1, 0, 0, 3, 32'(i), 32'(i + 100), 32'(dec_exp[i-1]), 32'(dec_exp[i-1] + 100), "decim");
        idle(2);

        send(0, 0, 0, 3, 32'd99, 32'd199, 32'd99, 32'd199, "bypass_clr");
        send(1, 0, 0, 4, 32'd10, 32'd110, 32'd10, 32'd110, "hold4_a");
        send(1, 0, 0, 4, 32'd11, 32'd111, 32'd10, 32'd110, "hold4_b");
        send(1, 0, 0, 4, 32'd12, 32'd112, 32'd10, 32'd110, "hold4_c");
        send(1, 0, 0, 2, 32'd13, 32'd113, 32'd10, 32'd110, "lower_h");
        send(1, 0, 0, 2, 32'd14, 32'd114, 32'd14, 32'd114, "recapture");
        send(0, 0, 0, 2, 32'd20, 32'd120, 32'd20, 32'd120, "bypass_mid");
        send(1, 0, 0, 2, 32'd21, 32'd121, 32'd21, 32'd121, "en_capture");
        send(1, 0, 31, 1, 32'h0000_00FF, 32'h8000_0000, 32'd21, 32'd121, "lower_to_1");
        send(1, 0, 31, 1, 32'h0000_00FF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, "chan_clamp");
        send(1, 1, 31, 1, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, "clamp_rnd");
        idle(1);

        send(1, 0, 0, 3, 32'd50, 32'd150, 32'd50, 32'd150, "prerst_a");
        send(1, 0, 0, 3, 32'd51, 32'd151, 32'd50, 32'd150, "prerst_b");
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        send(1, 0, 0, 3, 32'd60, 32'd160, 32'd60, 32'd160, "post_rst_capture");
        idle(1);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 9) < 7);
            enable       = ($urandom_range(0, 4) != 0);
            round_en     = 1'($urandom_range(0, 1));
            crush_bits   = CRUSH_W'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) hold_factor = HOLD_W'($urandom_range(0, 15));
            bus.l_audio_in = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF - 32'($urandom_range(0, 255))
                                                         : 32'($urandom());
            bus.r_audio_in = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + 32'($urandom_range(0, 255))
                                                         : 32'($urandom());
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
